// File: rtl/pipe_pkg.sv
// Shared defaults and state encoding for the pipeline register stage.
//   DATA_LEN_D / REG_SIZE_D / CTRL_W_D / NUM_DATA_D / CNT_W_D : default widths
//   stage_st_e : occupancy of the stage (EMPTY, FULL = main only, SKID = main + skid)
package pipe_pkg;

  localparam int DATA_LEN_D = 32;
  localparam int REG_SIZE_D = 5;
  localparam int CTRL_W_D   = 4;
  localparam int NUM_DATA_D = 2;
  localparam int CNT_W_D    = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_st_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage: a valid bit plus the ctrl/rd/data payload.
//   i_clk  : clock
//   i_clr  : zero valid and payload (wins over i_ld)
//   i_ld   : capture i_ctrl/i_rd/i_data and set valid
//   o_vld / o_ctrl / o_rd / o_data : registered slot contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_D,
  parameter int REG_SIZE = REG_SIZE_D,
  parameter int DW       = NUM_DATA_D * DATA_LEN_D
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic                i_ld,
  input  logic [CTRL_W-1:0]   i_ctrl,
  input  logic [REG_SIZE-1:0] i_rd,
  input  logic [DW-1:0]       i_data,
  output logic                o_vld,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic [REG_SIZE-1:0] o_rd,
  output logic [DW-1:0]       o_data
);

  logic                r_vld;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [REG_SIZE-1:0] r_rd;
  logic [DW-1:0]       r_data;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_vld  <= 1'b0;
      r_ctrl <= '0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (i_ld) begin
      r_vld  <= 1'b1;
      r_ctrl <= i_ctrl;
      r_rd   <= i_rd;
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_ctrl = r_ctrl;
  assign o_rd   = r_rd;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_reg_stage.sv
// Pipeline register stage with a one-entry skid buffer, so ready_o is a
// function of registered state only and never of ready_i.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   valid_i/ready_o         : upstream handshake (ctrl_i, rd_i, data_i payload)
//   flush_i                 : drop every held entry and any same-cycle input
//   valid_o/ready_i         : downstream handshake (ctrl_o, rd_o, data_o payload)
//   stall_cnt_o             : saturating count of valid_o & !ready_i cycles
module pipe_reg_stage
  import pipe_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_D,
  parameter int REG_SIZE = REG_SIZE_D,
  parameter int CTRL_W   = CTRL_W_D,
  parameter int NUM_DATA = NUM_DATA_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [CTRL_W-1:0]            ctrl_i,
  input  logic [REG_SIZE-1:0]          rd_i,
  input  logic [NUM_DATA*DATA_LEN-1:0] data_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [CTRL_W-1:0]            ctrl_o,
  output logic [REG_SIZE-1:0]          rd_o,
  output logic [NUM_DATA*DATA_LEN-1:0] data_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  localparam int DW = NUM_DATA * DATA_LEN;

  stage_st_e           r_state;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_in_fire, w_out_fire;
  logic                w_main_ld, w_main_clr, w_main_from_skid;
  logic                w_skid_ld, w_skid_clr;

  logic                w_main_vld, w_skid_vld;
  logic [CTRL_W-1:0]   w_main_ctrl, w_skid_ctrl, w_main_ctrl_d;
  logic [REG_SIZE-1:0] w_main_rd, w_skid_rd, w_main_rd_d;
  logic [DW-1:0]       w_main_data, w_skid_data, w_main_data_d;

  assign ready_o    = !w_skid_vld && !rst_i;
  assign w_in_fire  = valid_i && ready_o;
  assign w_out_fire = w_main_vld && ready_i;

  // Slot control. Reset and flush both wipe the slots; the FSM below
  // mirrors the same decisions for the state register.
  always_comb begin
    w_main_ld        = 1'b0;
    w_main_clr       = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    w_skid_clr       = 1'b0;
    if (rst_i || flush_i) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (r_state)
        EMPTY: w_main_ld = w_in_fire;
        FULL: begin
          if (w_in_fire && w_out_fire)  w_main_ld  = 1'b1;
          else if (w_in_fire)           w_skid_ld  = 1'b1;
          else if (w_out_fire)          w_main_clr = 1'b1;
        end
        SKID: begin
          // skid advances into main; upstream is stalled in this state
          if (w_out_fire) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) r_state <= FULL;
        FULL: begin
          if (w_in_fire && !w_out_fire)      r_state <= SKID;
          else if (!w_in_fire && w_out_fire) r_state <= EMPTY;
        end
        SKID:    if (w_out_fire) r_state <= FULL;
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Counter survives flush; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (w_main_vld && !ready_i && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : ctrl_i;
  assign w_main_rd_d   = w_main_from_skid ? w_skid_rd   : rd_i;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : data_i;

  pipe_slot #(.CTRL_W(CTRL_W), .REG_SIZE(REG_SIZE), .DW(DW)) u_main (
    .i_clk  (clk_i),
    .i_clr  (w_main_clr),
    .i_ld   (w_main_ld),
    .i_ctrl (w_main_ctrl_d),
    .i_rd   (w_main_rd_d),
    .i_data (w_main_data_d),
    .o_vld  (w_main_vld),
    .o_ctrl (w_main_ctrl),
    .o_rd   (w_main_rd),
    .o_data (w_main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .REG_SIZE(REG_SIZE), .DW(DW)) u_skid (
    .i_clk  (clk_i),
    .i_clr  (w_skid_clr),
    .i_ld   (w_skid_ld),
    .i_ctrl (ctrl_i),
    .i_rd   (rd_i),
    .i_data (data_i),
    .o_vld  (w_skid_vld),
    .o_ctrl (w_skid_ctrl),
    .o_rd   (w_skid_rd),
    .o_data (w_skid_data)
  );

  // Bubbles carry no write-enable and target x0.
  assign valid_o     = w_main_vld;
  assign ctrl_o      = w_main_vld ? w_main_ctrl : '0;
  assign rd_o        = w_main_vld ? w_main_rd   : '0;
  assign data_o      = w_main_data;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_reg_stage.sv
module tb_pipe_reg_stage;

  localparam int DL   = 32;
  localparam int RS   = 5;
  localparam int CW   = 4;
  localparam int ND   = 3;
  localparam int CNTW = 4;
  localparam int DW   = ND * DL;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [RS-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i, valid_i, flush_i, ready_i;
  logic            ready_o, valid_o;
  logic [CW-1:0]   ctrl_i, ctrl_o;
  logic [RS-1:0]   rd_i, rd_o;
  logic [DW-1:0]   data_i, data_o;
  logic [CNTW-1:0] stall_cnt_o;

  pipe_reg_stage #(
    .DATA_LEN(DL), .REG_SIZE(RS), .CTRL_W(CW), .NUM_DATA(ND), .CNT_W(CNTW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .rd_i        (rd_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .rd_o        (rd_o),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // Reference: the stage is a two-deep FIFO with a saturating stall counter.
  ent_t q[$];
  int   m_cnt = 0;
  bit   m_inf, m_outf;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst_i) begin
      q.delete();
      m_cnt = 0;
    end else begin
      m_inf  = valid_i && (q.size() < 2);
      m_outf = (q.size() > 0) && ready_i;
      if ((q.size() > 0) && !ready_i && (m_cnt < CMAX)) m_cnt++;
      if (flush_i) q.delete();
      else begin
        if (m_outf) void'(q.pop_front());
        if (m_inf)  q.push_back({ctrl_i, rd_i, data_i});
      end
    end
  end

  // Monitor: whatever the DUT presents must be the head of the reference FIFO.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid", 128'(valid_o), 128'(q.size() > 0));
      chk("mon_ready", 128'(ready_o), 128'(!rst_i && (q.size() < 2)));
      chk("mon_stall", 128'(stall_cnt_o), 128'(m_cnt));
      if (q.size() > 0 && valid_o) begin
        chk("mon_ctrl", 128'(ctrl_o), 128'(q[0].c));
        chk("mon_rd",   128'(rd_o),   128'(q[0].r));
        chk("mon_data", 128'(data_o), 128'(q[0].d));
      end else if (!valid_o) begin
        chk("mon_bubble_ctrl", 128'(ctrl_o), 128'(0));
        chk("mon_bubble_rd",   128'(rd_o),   128'(0));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then confirm ready_o did not react to ready_i.
  task automatic put(input bit r, input bit v, input bit f, input bit rdy,
                     input logic [CW-1:0] c, input logic [RS-1:0] rd,
                     input logic [DW-1:0] d);
    rst_i = r; valid_i = v; flush_i = f; ready_i = rdy;
    ctrl_i = c; rd_i = rd; data_i = d;
    #1;
    chk("ready_comb", 128'(ready_o), 128'(!r && (q.size() < 2)));
  endtask

  function automatic logic [DW-1:0] mkd(input int k);
    logic [31:0] a, b, cc;
    a  = 32'hA000_0000 + 32'(k);
    b  = 32'hB000_0000 + 32'(k);
    cc = 32'hC000_0000 + 32'(k);
    return {cc, b, a};
  endfunction

  task automatic do_reset();
    put(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    tick();
  endtask

  initial begin
    bit r, v, f, rdy;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    ctrl_i = '0; rd_i = '0; data_i = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    tick();

    // Reset state and single-entry latency
    do_reset();
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_ctrl",  128'(ctrl_o),  128'(0));
    chk("rst_rd",    128'(rd_o),    128'(0));
    chk("rst_data",  128'(data_o),  128'(0));
    chk("rst_stall", 128'(stall_cnt_o), 128'(0));
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'b1001, 5'd5, {32'h0, 32'hB, 32'hA});
    tick();
    chk("lat_valid", 128'(valid_o), 128'(1));
    chk("lat_ctrl",  128'(ctrl_o),  128'(4'b1001));
    chk("lat_rd",    128'(rd_o),    128'(5));
    chk("lat_data",  128'(data_o),  128'({32'h0, 32'hB, 32'hA}));
    put(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    tick();
    chk("lat_drain", 128'(valid_o), 128'(0));

    // Three-entry stream with downstream stall
    do_reset();
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 5'd1, mkd(1)); tick();
    put(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 5'd2, mkd(2)); tick();
    chk("skid_ready", 128'(ready_o), 128'(0));
    chk("skid_stall1", 128'(stall_cnt_o), 128'(1));
    chk("skid_head", 128'(rd_o), 128'(1));
    put(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 5'd3, mkd(3)); tick();
    chk("skid_stall2", 128'(stall_cnt_o), 128'(2));
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 5'd3, mkd(3)); tick();
    chk("order_2", 128'(rd_o), 128'(2));
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 5'd3, mkd(3)); tick();
    chk("order_3", 128'(rd_o), 128'(3));
    chk("order_3d", 128'(data_o), 128'(mkd(3)));
    put(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0); tick();
    chk("order_end", 128'(valid_o), 128'(0));

    // Flush while in SKID with a same-cycle offer
    do_reset();
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 5'd1, mkd(1)); tick();
    put(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 5'd2, mkd(2)); tick();
    put(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd9, mkd(9)); tick();
    chk("flush_valid", 128'(valid_o), 128'(0));
    chk("flush_ctrl",  128'(ctrl_o),  128'(0));
    chk("flush_rd",    128'(rd_o),    128'(0));
    chk("flush_ready", 128'(ready_o), 128'(1));
    put(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0); tick();
    chk("flush_gone", 128'(valid_o), 128'(0));

    // Stall counter saturation
    do_reset();
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 5'd4, mkd(4)); tick();
    for (int i = 0; i < 20; i++) begin
      put(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0); tick();
    end
    chk("sat_stall", 128'(stall_cnt_o), 128'(15));
    chk("sat_valid", 128'(valid_o), 128'(1));
    chk("sat_rd",    128'(rd_o), 128'(4));

    // Reset in SKID with stall count 7
    do_reset();
    put(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 5'd1, mkd(1)); tick();
    put(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 5'd2, mkd(2)); tick();
    for (int i = 0; i < 6; i++) begin
      put(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0); tick();
    end
    chk("pre_rst_stall", 128'(stall_cnt_o), 128'(7));
    chk("pre_rst_ready", 128'(ready_o), 128'(0));
    put(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0); tick();
    chk("mid_rst_valid", 128'(valid_o), 128'(0));
    chk("mid_rst_stall", 128'(stall_cnt_o), 128'(0));
    put(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("mid_rst_ready", 128'(ready_o), 128'(1));
    tick();

    // Random traffic, with periodic long downstream stalls
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      r   = ($urandom_range(0, 499) == 0);
      v   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 59) == 0);
      rdy = ((i % 200) < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      put(r, v, f, rdy, 4'($urandom), 5'($urandom), {$urandom, $urandom, $urandom});
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      put(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0); tick();
    end
    chk("final_drain", 128'(valid_o), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg_stage.md
PIPE_REG_STAGE -- requirements
Module: pipe_reg_stage

Interface
REQ-001 Parameter DATA_LEN, 32, width of one data lane.
REQ-002 Parameter REG_SIZE, 5, destination-register index width.
REQ-003 Parameter CTRL_W, 4, control-bit bundle width (e.g. RegWrite, MemtoReg, MemWrite, MemRead).
REQ-004 Parameter NUM_DATA, 2, number of DATA_LEN data lanes carried.
REQ-005 Parameter CNT_W, 16, stall-counter width.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 valid_i  in  1  upstream stage offers an entry.
REQ-010 ready_o  out  1  stage accepts an entry this cycle.
REQ-011 ctrl_i  in  CTRL_W  control bundle of the offered entry.
REQ-012 rd_i  in  REG_SIZE  destination register of the offered entry.
REQ-013 data_i  in  NUM_DATA*DATA_LEN  data lanes; lane k is bits [k*DATA_LEN +: DATA_LEN].
REQ-014 flush_i  in  1  discard all held entries.
REQ-015 valid_o  out  1  stage presents an entry downstream.
REQ-016 ready_i  in  1  downstream accepts the presented entry.
REQ-017 ctrl_o  out  CTRL_W  control bundle of the presented entry.
REQ-018 rd_o  out  REG_SIZE  destination register of the presented entry.
REQ-019 data_o  out  NUM_DATA*DATA_LEN  data lanes of the presented entry.
REQ-020 stall_cnt_o  out  CNT_W  count of downstream-stall cycles.

Function
REQ-021 in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
REQ-022 Storage: one main slot plus one skid slot; states EMPTY (none valid), FULL (main valid), SKID (main and skid valid).
REQ-023 ready_o = !skid_valid & !rst_i, driven from registered state only (no combinational path from ready_i).
REQ-024 EMPTY: in_fire -> FULL, main loaded with inputs; else stay.
REQ-025 FULL: in_fire & out_fire -> FULL, main loaded with inputs; in_fire & !out_fire -> SKID, skid loaded; !in_fire & out_fire -> EMPTY; else hold.
REQ-026 SKID: out_fire -> FULL, main loaded from skid; else hold; no input accepted.
REQ-027 Latency: entry accepted at edge N appears on outputs after edge N when slot order permits; order strictly FIFO, no entry lost or duplicated.
REQ-028 valid_o = main_valid; ctrl_o and rd_o forced to zero whenever valid_o=0 (bubble writes nothing, forwards to x0).
REQ-029 data_o is main data regardless of valid_o; value undefined after flush until next load.
REQ-030 flush_i high at an edge: next state EMPTY; any same-cycle in_fire is discarded; flush overrides all transitions except reset.
REQ-031 Held entry (valid_o & !ready_i) keeps all outputs bit-stable.
REQ-032 stall_cnt_o increments by 1 each cycle valid_o & !ready_i; saturates at all-ones; not cleared by flush_i.

Reset
REQ-033 rst_i high at an edge: state EMPTY, both slots invalid, main/skid data, ctrl, rd zeroed, stall_cnt_o = 0.
REQ-034 Reset mid-operation drops both held entries with no downstream valid_o on the following cycle.
REQ-035 rst_i has priority over flush_i and all handshakes.

Structure
REQ-036 Package pipe_pkg holds DATA_LEN, REG_SIZE defaults and the EMPTY/FULL/SKID state enum.
REQ-037 Sub-module pipe_slot (valid bit plus ctrl/rd/data register, load and clear inputs) instantiated twice: main and skid.

Verification
REQ-038 Reset, then valid_i=1, ctrl_i=4'b1001, rd_i=5, lanes 0xA/0xB, ready_i=1 -> next cycle valid_o=1, ctrl_o=4'b1001, rd_o=5, data_o lanes 0xA/0xB.
REQ-039 Stream 3 entries, ready_i=0 from cycle 2 -> second entry in skid, ready_o=0, stall_cnt_o increments each cycle; ready_i=1 -> entries emerge in order 1,2,3, none lost.
REQ-040 SKID state, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ctrl_o=0, rd_o=0, ready_o=1; flushed input never appears.
REQ-041 CNT_W=4, hold ready_i=0 for 20 cycles with valid_o=1 -> stall_cnt_o stops at 15.
REQ-042 rst_i asserted while SKID with stall_cnt_o=7 -> next cycle valid_o=0, ready_o=1, stall_cnt_o=0.
REQ-043 Random valid_i/ready_i/flush_i for 10k cycles, NUM_DATA=3 -> scoreboard matches FIFO order, ready_o never depends combinationally on ready_i.
